// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read sequencer.
// Holds the SPI-master register offsets, CTRL bit patterns, flash command codes,
// the sequencer state encoding and a helper that selects the outgoing stream byte.
package spi_flash_pkg;

  // SPI-master register offsets
  localparam logic [31:0] RegCtrl   = 32'h0000_0000;
  localparam logic [31:0] RegData   = 32'h0000_0004;
  localparam logic [31:0] RegStatus = 32'h0000_0008;

  // CTRL[7:0]: bit0 enable/start, bit3 slave select, CPOL=CPHA=0
  localparam logic [7:0] CtrlEnSel = 8'h09;
  localparam logic [7:0] CtrlOff   = 8'h00;

  // Flash commands
  localparam logic [7:0] CmdRead     = 8'h03;
  localparam logic [7:0] CmdFastRead = 8'h0B;

  // Bus transfer size: always 32-bit word
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLdData,
    StStart,
    StGuard,
    StPoll,
    StCapt,
    StDesel,
    StDone
  } state_e;

  // Byte idx of the outgoing stream: cmd, three address bytes, then zeros
  // (dummy byte and data-phase bytes are all 0x00).
  function automatic logic [7:0] stream_byte(input logic [7:0]  cmd,
                                             input logic [23:0] addr,
                                             input logic [3:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = cmd;
      4'd1:    b = addr[23:16];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_rd.sv
// SPI flash read sequencer. Drives an SPI-master register block to issue a
// READ (0x03) command with a 24-bit address and collect 1..4 data bytes.
// Optional macro SPI_FLASH_RD_FAST_EN: use FAST READ (0x0B) with one dummy
// byte after the address; the dummy byte's read value is discarded.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i              start a read (sampled only when idle)
//   flash_addr_i, len_i  flash byte address, byte count minus one
//   busy_o, done_o     operation in progress, one-cycle completion pulse
//   rdata_o            read bytes, first byte in [7:0], unused bytes zero
//   m_*                SPI-master register bus (CTRL 0x0, DATA 0x4, STATUS 0x8)
module spi_flash_rd
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] DIV = 8'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [23:0] flash_addr_i,
  input  logic [1:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic        m_wr_o,
  output logic        m_rd_o,
  output logic [1:0]  m_size_o,
  input  logic [31:0] m_rdata_i
);

`ifdef SPI_FLASH_RD_FAST_EN
  localparam logic [7:0] Cmd      = CmdFastRead;
  localparam logic [3:0] HdrBytes = 4'd5;
`else
  localparam logic [7:0] Cmd      = CmdRead;
  localparam logic [3:0] HdrBytes = 4'd4;
`endif

  state_e      state_q, state_d;
  logic [23:0] addr_q;
  logic [1:0]  len_q;
  logic [3:0]  cnt_q, cnt_d;      // index of the byte currently in flight
  logic        guard_q, guard_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  last_idx;
  logic [1:0]  data_idx;
  logic        accept;
  logic        unused_rdata;

  assign accept       = (state_q == StIdle) && req_i;
  assign last_idx     = HdrBytes + {2'b00, len_q};
  assign data_idx     = 2'(cnt_q - HdrBytes);
  assign unused_rdata = ^m_rdata_i[31:8];
  assign m_size_o     = SizeWord;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    rdata_d   = rdata_q;
    m_wr_o    = 1'b0;
    m_rd_o    = 1'b0;
    m_addr_o  = 32'h0;
    m_wdata_o = 32'h0;
    done_o    = 1'b0;
    busy_o    = (state_q != StIdle);
    rdata_o   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StLdData;
          cnt_d   = 4'd0;
          rdata_d = 32'h0;
        end
      end
      StLdData: begin
        m_wr_o    = 1'b1;
        m_addr_o  = RegData;
        m_wdata_o = {24'h0, stream_byte(Cmd, addr_q, cnt_q)};
        state_d   = StStart;
      end
      StStart: begin
        m_wr_o    = 1'b1;
        m_addr_o  = RegCtrl;
        m_wdata_o = {16'h0, DIV, CtrlEnSel};
        guard_d   = 1'b0;
        state_d   = StGuard;
      end
      StGuard: begin
        // STATUS busy bit lags the CTRL write; wait two cycles before polling
        if (guard_q) state_d = StPoll;
        else         guard_d = 1'b1;
      end
      StPoll: begin
        m_rd_o   = 1'b1;
        m_addr_o = RegStatus;
        if (!m_rdata_i[0]) state_d = StCapt;
      end
      StCapt: begin
        m_rd_o   = 1'b1;
        m_addr_o = RegData;
        // Header and dummy bytes return junk; only data-phase bytes are kept
        if (cnt_q >= HdrBytes) rdata_d[{data_idx, 3'b000} +: 8] = m_rdata_i[7:0];
        if (cnt_q == last_idx) begin
          state_d = StDesel;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = StLdData;
        end
      end
      StDesel: begin
        m_wr_o    = 1'b1;
        m_addr_o  = RegCtrl;
        m_wdata_o = {16'h0, DIV, CtrlOff};
        state_d   = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs read as reset values for the whole time reset is held
    if (rst_i) begin
      m_wr_o    = 1'b0;
      m_rd_o    = 1'b0;
      m_addr_o  = 32'h0;
      m_wdata_o = 32'h0;
      done_o    = 1'b0;
      busy_o    = 1'b0;
      rdata_o   = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      guard_q <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= 24'h0;
      len_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q <= flash_addr_i;
        len_q  <= len_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Self-checking bench for spi_flash_rd with a behavioural SPI-master model.
module tb_spi_flash_rd;

  localparam logic [7:0] Div = 8'd4;
`ifdef SPI_FLASH_RD_FAST_EN
  localparam int         Hdr = 5;
  localparam logic [7:0] Cmd = 8'h0B;
`else
  localparam int         Hdr = 4;
  localparam logic [7:0] Cmd = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        rst, req;
  logic [23:0] flash_addr;
  logic [1:0]  len;
  logic        busy, done;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic        m_wr, m_rd;
  logic [1:0]  m_size;

  always #5 clk = ~clk;

  spi_flash_rd #(.DIV(Div)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .flash_addr_i(flash_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .rdata_o     (rdata),
    .m_addr_o    (m_addr),
    .m_wdata_o   (m_wdata),
    .m_wr_o      (m_wr),
    .m_rd_o      (m_rd),
    .m_size_o    (m_size),
    .m_rdata_i   (m_rdata)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SPI-master model: each start write launches one byte, busy for busy_len cycles,
  // and the received byte is the next entry of resp_q.
  logic [7:0] resp_q[$];
  int         busy_len = 3;
  int         busy_cnt = 0;
  logic [7:0] rx = 8'h00;

  assign m_rdata = (m_addr == 32'h8) ? {31'h0, busy_cnt != 0} :
                   (m_addr == 32'h4) ? {24'hABCDEF, rx} : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (m_wr && m_addr == 32'h0 && m_wdata[0]) begin
      busy_cnt <= busy_len;
      if (resp_q.size() > 0) rx <= resp_q.pop_front();
      else                   rx <= 8'hEE;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Expected per-operation behaviour
  logic [7:0]  exp_wr_q[$];
  logic [31:0] exp_rdata;
  int start_cnt, desel_cnt, done_cnt, busy_poll_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      check("size", {30'h0, m_size}, 32'h2);
      check("wr_rd_excl", {31'h0, m_wr & m_rd}, 32'h0);
      if (m_wr && m_addr == 32'h4) begin
        if (exp_wr_q.size() == 0) check("data_wr_extra", m_wdata, 32'hFFFF_FFFF);
        else                      check("data_wr", m_wdata, {24'h0, exp_wr_q.pop_front()});
      end
      if (m_wr && m_addr == 32'h0) begin
        if (m_wdata[0]) begin
          start_cnt++;
          check("ctrl_start", m_wdata, {16'h0, Div, 8'h09});
        end else begin
          desel_cnt++;
          check("ctrl_desel", m_wdata, {16'h0, Div, 8'h00});
        end
      end
      if (m_rd && m_addr == 32'h8 && busy_cnt != 0) busy_poll_cnt++;
      if (m_rd && m_addr == 32'h4) check("data_rd_while_busy", {31'h0, busy_cnt != 0}, 32'h0);
      if (done) begin
        done_cnt++;
        check("rdata_at_done", rdata, exp_rdata);
      end
    end
  end

  task automatic setup_op(input logic [23:0] a, input logic [1:0] l, input logic [31:0] d,
                          input int bl);
    exp_wr_q.delete();
    resp_q.delete();
    exp_wr_q.push_back(Cmd);
    exp_wr_q.push_back(a[23:16]);
    exp_wr_q.push_back(a[15:8]);
    exp_wr_q.push_back(a[7:0]);
    if (Hdr == 5) exp_wr_q.push_back(8'h00);
    for (int i = 0; i < Hdr; i++) resp_q.push_back(8'hEE);
    exp_rdata = 32'h0;
    for (int i = 0; i <= int'(l); i++) begin
      exp_wr_q.push_back(8'h00);
      resp_q.push_back(d[8*i +: 8]);
      exp_rdata[8*i +: 8] = d[8*i +: 8];
    end
    busy_len      = bl;
    start_cnt     = 0;
    desel_cnt     = 0;
    done_cnt      = 0;
    busy_poll_cnt = 0;
    flash_addr    = a;
    len           = l;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 4000 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic finish_op(input string name, input int starts);
    check({name, "_writes_left"}, exp_wr_q.size(), 0);
    check({name, "_starts"}, start_cnt, starts);
    check({name, "_desel"}, desel_cnt, 1);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check({name, "_rdata_hold"}, rdata, exp_rdata);
    check({name, "_done_pulses_after"}, done_cnt, 1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", {31'h0, busy}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    flash_addr = 24'h0;
    len = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus", {m_addr[29:0], m_wr, m_rd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", {31'h0, done}, 32'h0);

    // Four-byte read
    setup_op(24'h123456, 2'd3, 32'hC33C5AA5, 3);
    pulse_req();
    wait_done("len3");
    check("len3_rdata_literal", rdata, 32'hC33C5AA5);
    finish_op("len3", Hdr + 4);

    // Single-byte read with a slow STATUS
    setup_op(24'h0000AA, 2'd0, 32'h0000007E, 40);
    pulse_req();
    wait_done("len0_slow");
    check("len0_rdata_literal", rdata, 32'h0000007E);
    check("len0_busy_polls", busy_poll_cnt, 38 * (Hdr + 1));
    finish_op("len0_slow", Hdr + 1);

    // Two-byte read at 0x000010 (dummy byte present only in the fast build)
    setup_op(24'h000010, 2'd1, 32'h00002211, 2);
    pulse_req();
    wait_done("len1");
    check("len1_rdata_literal", rdata, 32'h00002211);
    finish_op("len1", Hdr + 2);

    // req_i held every cycle while busy; address input scrambled mid-operation
    setup_op(24'h654321, 2'd2, 32'h00998877, 1);
    @(negedge clk);
    req = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      flash_addr = 24'($urandom);
      len = 2'($urandom);
      if (done) break;
    end
    req = 1'b0;
    check("req_spam_done_seen", {31'h0, done}, 32'h1);
    @(negedge clk);
    finish_op("req_spam", Hdr + 3);

    // Reset during POLL of byte index 2
    setup_op(24'hABCDEF, 2'd3, 32'h44332211, 3);
    pulse_req();
    begin
      int n;
      n = 0;
      while (n < 4000 && !(start_cnt == 3 && m_rd && m_addr == 32'h8)) begin
        @(negedge clk);
        n++;
      end
      check("reached_poll_byte2", {31'h0, m_rd}, 32'h1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_done", {30'h0, busy, done}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_wr_rd", {30'h0, m_wr, m_rd}, 32'h0);
    check("abort_addr", m_addr, 32'h0);
    check("abort_wdata", m_wdata, 32'h0);
    @(negedge clk);
    check("abort_desel_none", desel_cnt, 0);
    rst = 1'b0;
    setup_op(24'h0F0E0D, 2'd3, 32'hDDCCBBAA, 3);
    pulse_req();
    wait_done("after_abort");
    check("after_abort_rdata_literal", rdata, 32'hDDCCBBAA);
    finish_op("after_abort", Hdr + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
